// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the keypad matrix scanner.
package keypad_pkg;

   localparam int unsigned ROWS   = 4;
   localparam int unsigned COLS   = 4;
   localparam int unsigned CODE_W = 4;
   localparam int unsigned IDX_W  = 2;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } kp_state_e;

   // Active-low one-hot row drive for a row index.
   function automatic logic [ROWS-1:0] row_drive(input logic [IDX_W-1:0] idx);
      return ~(ROWS'(1) << idx);
   endfunction

   // Index of the lowest-numbered column that reads low.
   function automatic logic [IDX_W-1:0] first_low(input logic [COLS-1:0] cols);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = int'(COLS) - 1; i >= 0; i--) begin
         if (!cols[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan tick divider: one-cycle tick every SCAN_DIV clocks.
module keypad_tick_gen #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rstn,
   output logic tick
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (cnt == CNT_W'(SCAN_DIV - 1));
         if (cnt == CNT_W'(SCAN_DIV - 1)) cnt <= '0;
         else                             cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad matrix scanner: row scan, debounce, press/release tracking, event handshake.
// Define KEYPAD_REPEAT_EN to add auto-repeat events while a key stays held.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned DEB_TICKS    = 20,
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [COLS-1:0]   col_in,
   output logic [ROWS-1:0]   row_out,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              key_held,
   output logic              overrun,
   input  logic              clr_ovr
);

   // One width serves both the debounce and the repeat counters.
   localparam int unsigned CNT_W = $clog2(max3(DEB_TICKS, REPEAT_DELAY, REPEAT_RATE) + 1);

   logic [COLS-1:0]  col_meta, col_sync;
   kp_state_e        state;
   logic [IDX_W-1:0] row_idx, col_idx, row_nxt_c;
   logic [CNT_W-1:0] deb_cnt;
   logic             tick, col_low_c, deb_done_c, evt_c, drop_c;
`ifdef KEYPAD_REPEAT_EN
   logic [CNT_W-1:0] rep_cnt;
   logic             rep_first, rep_hit_c;
`endif

   keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk  (clk),
      .rstn (rstn),
      .tick (tick)
   );

   // Event qualification for the current tick.
   always_comb begin
      row_nxt_c  = row_idx + IDX_W'(1);
      col_low_c  = !col_sync[col_idx];
      deb_done_c = (deb_cnt == CNT_W'(DEB_TICKS - 1));
`ifdef KEYPAD_REPEAT_EN
      rep_hit_c  = rep_first ? (rep_cnt == CNT_W'(REPEAT_DELAY - 1))
                             : (rep_cnt == CNT_W'(REPEAT_RATE - 1));
`endif
      evt_c = 1'b0;
      if (tick && col_low_c) begin
         case (state)
            ST_DEBOUNCE: evt_c = deb_done_c;
`ifdef KEYPAD_REPEAT_EN
            ST_PRESSED:  evt_c = rep_hit_c;
`endif
            default:     evt_c = 1'b0;
         endcase
      end
      drop_c = evt_c && key_valid && !key_ready;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         col_meta  <= '1;
         col_sync  <= '1;
         state     <= ST_SCAN;
         row_idx   <= '0;
         col_idx   <= '0;
         deb_cnt   <= '0;
         row_out   <= row_drive('0);
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         overrun   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= '0;
         rep_first <= 1'b1;
`endif
      end else begin
         col_meta <= col_in;
         col_sync <= col_meta;
         if (tick) begin
            case (state)
               ST_SCAN: begin
                  if (&col_sync) begin
                     row_idx <= row_nxt_c;
                     row_out <= row_drive(row_nxt_c);
                  end else begin
                     col_idx <= first_low(col_sync);
                     deb_cnt <= '0;
                     state   <= ST_DEBOUNCE;
                  end
               end
               ST_DEBOUNCE: begin
                  if (!col_low_c) begin
                     state   <= ST_SCAN;
                     row_idx <= row_nxt_c;
                     row_out <= row_drive(row_nxt_c);
                  end else if (deb_done_c) begin
                     state    <= ST_PRESSED;
                     key_held <= 1'b1;
                  end else begin
                     deb_cnt <= deb_cnt + CNT_W'(1);
                  end
               end
               ST_PRESSED: begin
                  if (!col_low_c) begin
                     state   <= ST_RELEASE;
                     deb_cnt <= '0;
                  end
`ifdef KEYPAD_REPEAT_EN
                  if (!col_low_c) begin
                     rep_cnt   <= '0;
                     rep_first <= 1'b1;
                  end else if (rep_hit_c) begin
                     rep_cnt   <= '0;
                     rep_first <= 1'b0;
                  end else begin
                     rep_cnt <= rep_cnt + CNT_W'(1);
                  end
`endif
               end
               ST_RELEASE: begin
                  if (col_low_c) begin
                     state <= ST_PRESSED;
                  end else if (deb_done_c) begin
                     state    <= ST_SCAN;
                     key_held <= 1'b0;
                     row_idx  <= row_nxt_c;
                     row_out  <= row_drive(row_nxt_c);
                  end else begin
                     deb_cnt <= deb_cnt + CNT_W'(1);
                  end
               end
               default: state <= ST_SCAN;
            endcase
         end

         // Event delivery: a pending unaccepted event keeps its code and flags the loss.
         if (drop_c)       overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;

         if (evt_c && !drop_c) begin
            key_code  <= CODE_W'({row_idx, col_idx});
            key_valid <= 1'b1;
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per scan tick.
REQ-002 SHALL have parameter DEB_TICKS, default 20, consecutive stable ticks required to accept a press or release.
REQ-003 SHALL have parameter REPEAT_DELAY, default 500, ticks of hold before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_RATE, default 100, ticks between later auto-repeats.
REQ-005 SHALL have port clk, input, 1, sole clock; one clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port col_in, input, 4, matrix columns; active-low, asynchronous, pulled up.
REQ-008 SHALL have port row_out, output, 4, matrix row drive; active-low; exactly one bit low at all times.
REQ-009 SHALL have port key_code, output, 4, code = row*4 + col.
REQ-010 SHALL have port key_valid, output, 1, key event available.
REQ-011 SHALL have port key_ready, input, 1, consumer accepts the event.
REQ-012 SHALL have port key_held, output, 1, debounced pressed level.
REQ-013 SHALL have port overrun, output, 1, sticky dropped-event flag.
REQ-014 SHALL have port clr_ovr, input, 1, clears overrun.

Function
REQ-015 SHALL pass col_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 SHALL generate a one-cycle tick every SCAN_DIV clocks; the divider counts 0..SCAN_DIV-1 and wraps.
REQ-017 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE; all transitions occur only on tick.
REQ-018 SCAN: on tick, if all columns are high, the row index SHALL advance r -> (r+1) mod 4 (3 wraps to 0); if any column is low, it SHALL latch r and the lowest-index low column, clear deb_cnt and go to DEBOUNCE.
REQ-019 DEBOUNCE: row SHALL stay fixed; on tick, if the latched column is low, deb_cnt increments; on reaching DEB_TICKS, go to PRESSED and issue an event; if the column is high, go to SCAN with the row advanced.
REQ-020 PRESSED: key_held SHALL be 1; on tick with the latched column high, go to RELEASE with deb_cnt cleared.
REQ-021 RELEASE: DEB_TICKS consecutive high ticks SHALL go to SCAN with the row advanced; a low tick returns to PRESSED with no new event; key_held SHALL stay 1 until SCAN is entered.
REQ-022 An event SHALL load key_code and set key_valid on the clock edge after the issuing tick.
REQ-023 key_code SHALL be stable while key_valid=1; key_valid SHALL clear the cycle after key_valid&&key_ready.
REQ-024 If an event occurs while key_valid=1 and key_ready=0, it SHALL be dropped, key_code SHALL be kept, and overrun set.
REQ-025 If an event occurs in the same cycle as key_valid&&key_ready, the new code SHALL load and key_valid SHALL remain 1.
REQ-026 clr_ovr SHALL clear overrun; a simultaneous set wins over clear.

Reset
REQ-027 With rstn=0 at a clk edge: state=SCAN, row_out=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0, all counters=0, synchronizer flops=4'hF.
REQ-028 Reset mid-operation SHALL abort any debounce or hold without emitting an event.

Configuration
REQ-029 With KEYPAD_REPEAT_EN defined, PRESSED SHALL issue an event with the same code after REPEAT_DELAY ticks of hold, then every REPEAT_RATE ticks; the repeat counter clears on leaving PRESSED.
REQ-030 Without KEYPAD_REPEAT_EN, there SHALL be exactly one event per accepted press, and no repeat counter logic.

Structure
REQ-031 Package keypad_pkg SHALL hold the state enum, ROWS=4, COLS=4 and the key code width (4).
REQ-032 The tick divider SHALL be sub-module keypad_tick_gen (parameter SCAN_DIV; outputs tick); all other logic stays in keypad_scan_ctrl.

Verification (SCAN_DIV=4, DEB_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-033 Reset: rstn=0 for 2 cycles -> row_out=1110, key_valid=0, key_held=0, overrun=0.
REQ-034 Clean press row2/col1 for 10 ticks, key_ready=1 -> exactly one event, key_code=9; key_held=1 until 3 high ticks after release.
REQ-035 Bounce: col0 low 2 ticks then high -> no key_valid; row scan resumes at next row.
REQ-036 key_ready=0, press 5 then press 6 -> key_code stays 5, overrun=1; clr_ovr pulse -> overrun=0.
REQ-037 Row1 with col2 and col0 low together -> key_code=4; rstn=0 mid-DEBOUNCE -> no event, outputs at reset values.
REQ-038 KEYPAD_REPEAT_EN, hold key 3 for 12 ticks after acceptance -> events at acceptance, +5, +7, +9, +11 ticks; without the macro -> one event only.
